// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 built-in self-test controller.
// Holds the FSM state enum, LFSR/SISR polynomials and the SISR step helper.
package s27_bist_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned SIG_W  = 16;
  localparam int unsigned CNT_W  = 16;

  // x^8+x^6+x^5+x^4+1 expressed as taps on bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam logic [SIG_W-1:0]  SISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StRun,
    StDone
  } bist_state_e;

  function automatic logic [SIG_W-1:0] sisr_step(input logic [SIG_W-1:0] sisr, input logic din);
    logic fb;
    fb = sisr[SIG_W-1] ^ din;
    return {sisr[SIG_W-2:0], 1'b0} ^ (fb ? SISR_POLY : '0);
  endfunction

endpackage

// File: rtl/s27_bist_if.sv
// Control/observe bundle between the BIST controller (master) and its host/CUT (slave).
interface s27_bist_if;
  logic        start;
  logic        abort;
  logic        cut_out;
  logic [3:0]  cut_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  modport master (
    input  start, abort, cut_out,
    output cut_in, busy, done, pass, signature
  );

  modport slave (
    output start, abort, cut_out,
    input  cut_in, busy, done, pass, signature
  );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (shift left) with synchronous reload; exposes the low nibble of
// the value it will hold after the coming edge so the parent can register it alongside.
module lfsr8
  import s27_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  output logic [3:0] pat_next
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign pat_next = lfsr_d[3:0];

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST controller for the s27 benchmark: LFSR stimulus on G0..G3, SISR compaction of G17,
// and a pass/fail verdict against a build-time golden signature.
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'h01,
  parameter int unsigned       WARMUP_CYCLES = 4,
  parameter int unsigned       PAT_COUNT     = 255,
  parameter logic [SIG_W-1:0]  SIG_SEED      = 16'hFFFF,
  parameter logic [SIG_W-1:0]  GOLDEN_SIG    = 16'h0000
) (
  input logic        CK,
  input logic        RSTN,
  s27_bist_if.master bist
);

  // An all-zero seed would lock the LFSR up
  localparam logic [LFSR_W-1:0] LFSR_INIT = (LFSR_SEED == '0) ? 8'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PAT_LAST  = CNT_W'(PAT_COUNT - 1);
  localparam bist_state_e START_STATE = (WARMUP_CYCLES != 0) ? StWarmup :
                                        (PAT_COUNT != 0)     ? StRun    : StDone;

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] sisr_q, sisr_d;
  logic [3:0]       cut_in_q, pat_next;
  logic             busy_q, done_q, pass_q;
  logic             lfsr_en, lfsr_load, active_d;

  lfsr8 #(
    .SEED(LFSR_INIT)
  ) u_lfsr8 (
    .clk     (CK),
    .rst_n   (RSTN),
    .en      (lfsr_en),
    .load    (lfsr_load),
    .pat_next(pat_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sisr_d    = sisr_q;
    lfsr_en   = 1'b0;
    lfsr_load = 1'b0;
    if (bist.abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bist.start) begin
            lfsr_load = 1'b1;
            sisr_d    = SIG_SEED;
            cnt_d     = '0;
            state_d   = START_STATE;
          end
        end
        StWarmup: begin
          lfsr_en = 1'b1;
          if (cnt_q == WARM_LAST) begin
            cnt_d   = '0;
            state_d = (PAT_COUNT == 0) ? StDone : StRun;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          lfsr_en = 1'b1;
          sisr_d  = sisr_step(sisr_q, bist.cut_out);
          if (cnt_q == PAT_LAST) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign active_d = (state_d == StWarmup) || (state_d == StRun);

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sisr_q   <= SIG_SEED;
      cut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sisr_q   <= sisr_d;
      cut_in_q <= active_d ? pat_next : '0;
      busy_q   <= active_d;
      done_q   <= (state_d == StDone);
      pass_q   <= (state_d == StDone) && (sisr_d == GOLDEN_SIG);
    end
  end

  assign bist.cut_in    = cut_in_q;
  assign bist.busy      = busy_q;
  assign bist.done      = done_q;
  assign bist.pass      = pass_q;
  assign bist.signature = sisr_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Self-checking bench: four differently configured controllers share random stimulus and
// are compared every cycle against a run-timeline reference model.
module tb_s27_bist_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned  CFG_W    [N] = '{4, 0, 0, 3};
  localparam int unsigned  CFG_P    [N] = '{255, 1, 0, 20};
  localparam logic [7:0]   CFG_SEED [N] = '{8'h01, 8'hC3, 8'h5A, 8'h00};
  localparam logic [15:0]  CFG_SIG  [N] = '{16'hFFFF, 16'hFFFF, 16'h1234, 16'hABCD};
  localparam logic [15:0]  CFG_GOLD [N] = '{16'h0000, 16'hEFDF, 16'h1234, 16'h0000};

  logic CK, RSTN, start, abort, cut_out;
  int   n_checks, n_errors;

  s27_bist_if ifa ();
  s27_bist_if ifb ();
  s27_bist_if ifc ();
  s27_bist_if ifd ();

  assign ifa.start = start;  assign ifa.abort = abort;  assign ifa.cut_out = cut_out;
  assign ifb.start = start;  assign ifb.abort = abort;  assign ifb.cut_out = cut_out;
  assign ifc.start = start;  assign ifc.abort = abort;  assign ifc.cut_out = cut_out;
  assign ifd.start = start;  assign ifd.abort = abort;  assign ifd.cut_out = cut_out;

  // {cut_in, busy, done, pass, signature}
  logic [22:0] obs [N];
  assign obs[0] = {ifa.cut_in, ifa.busy, ifa.done, ifa.pass, ifa.signature};
  assign obs[1] = {ifb.cut_in, ifb.busy, ifb.done, ifb.pass, ifb.signature};
  assign obs[2] = {ifc.cut_in, ifc.busy, ifc.done, ifc.pass, ifc.signature};
  assign obs[3] = {ifd.cut_in, ifd.busy, ifd.done, ifd.pass, ifd.signature};

  s27_bist_ctrl #(.LFSR_SEED(CFG_SEED[0]), .WARMUP_CYCLES(CFG_W[0]), .PAT_COUNT(CFG_P[0]),
    .SIG_SEED(CFG_SIG[0]), .GOLDEN_SIG(CFG_GOLD[0])) u_dut_a (.CK(CK), .RSTN(RSTN), .bist(ifa));
  s27_bist_ctrl #(.LFSR_SEED(CFG_SEED[1]), .WARMUP_CYCLES(CFG_W[1]), .PAT_COUNT(CFG_P[1]),
    .SIG_SEED(CFG_SIG[1]), .GOLDEN_SIG(CFG_GOLD[1])) u_dut_b (.CK(CK), .RSTN(RSTN), .bist(ifb));
  s27_bist_ctrl #(.LFSR_SEED(CFG_SEED[2]), .WARMUP_CYCLES(CFG_W[2]), .PAT_COUNT(CFG_P[2]),
    .SIG_SEED(CFG_SIG[2]), .GOLDEN_SIG(CFG_GOLD[2])) u_dut_c (.CK(CK), .RSTN(RSTN), .bist(ifc));
  s27_bist_ctrl #(.LFSR_SEED(CFG_SEED[3]), .WARMUP_CYCLES(CFG_W[3]), .PAT_COUNT(CFG_P[3]),
    .SIG_SEED(CFG_SIG[3]), .GOLDEN_SIG(CFG_GOLD[3])) u_dut_d (.CK(CK), .RSTN(RSTN), .bist(ifd));

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per controller, whether a run is live, which cycle of it we are in
  // (1-based), the pattern generator value and the compacted signature.
  bit          m_act [N];
  int unsigned m_t   [N];
  logic [7:0]  m_lf  [N];
  logic [15:0] m_sig [N];

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [15:0] crc_next(input logic [15:0] s, input logic b);
    return (s << 1) ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 1'b0;
      m_t[i]   = 0;
      m_sig[i] = CFG_SIG[i];
    end
  endtask

  task automatic model_step();
    if (!RSTN) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (abort) begin
        m_act[i] = 1'b0;
      end else if (m_act[i] && m_t[i] <= CFG_W[i] + CFG_P[i]) begin
        if (m_t[i] > CFG_W[i]) m_sig[i] = crc_next(m_sig[i], cut_out);
        m_lf[i] = lfsr_next(m_lf[i]);
        m_t[i]++;
      end else if (start) begin
        m_act[i] = 1'b1;
        m_t[i]   = 1;
        m_lf[i]  = (CFG_SEED[i] == 8'h00) ? 8'h01 : CFG_SEED[i];
        m_sig[i] = CFG_SIG[i];
      end
    end
  endtask

  task automatic check_all();
    logic e_busy, e_done, e_pass;
    logic [3:0] e_cut;
    for (int i = 0; i < N; i++) begin
      e_busy = m_act[i] && (m_t[i] <= CFG_W[i] + CFG_P[i]);
      e_done = m_act[i] && (m_t[i] >  CFG_W[i] + CFG_P[i]);
      e_cut  = e_busy ? m_lf[i][3:0] : 4'h0;
      e_pass = e_done && (m_sig[i] == CFG_GOLD[i]);
      check($sformatf("cut_in%0d", i),    32'(obs[i][22:19]), 32'(e_cut));
      check($sformatf("busy%0d", i),      32'(obs[i][18]),    32'(e_busy));
      check($sformatf("done%0d", i),      32'(obs[i][17]),    32'(e_done));
      check($sformatf("pass%0d", i),      32'(obs[i][16]),    32'(e_pass));
      check($sformatf("signature%0d", i), 32'(obs[i][15:0]),  32'(m_sig[i]));
    end
  endtask

  task automatic cycle();
    @(posedge CK);
    model_step();
    @(negedge CK);
    check_all();
  endtask

  logic [3:0]  seq [6];
  logic [15:0] exp_full;
  int          busy_n, done_at;

  initial begin
    seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h3};
    exp_full = 16'hFFFF;
    for (int k = 0; k < 255; k++) exp_full = crc_next(exp_full, 1'b0);
    n_checks = 0;
    n_errors = 0;
    RSTN = 1'b0; start = 1'b0; abort = 1'b0; cut_out = 1'b0;
    model_reset();
    repeat (2) cycle();
    check("rst_sig", 32'(ifa.signature), 32'hFFFF);
    check("rst_cut", 32'(ifa.cut_in), 32'h0);
    RSTN = 1'b1;

    // Default run with G17 held low
    start = 1'b1;
    cycle();
    start = 1'b0;
    busy_n = 0;
    done_at = 0;
    for (int n = 1; n <= 300; n++) begin
      if (n <= 6) check($sformatf("seq%0d", n), 32'(ifa.cut_in), 32'(seq[n-1]));
      if (ifa.busy) busy_n++;
      if (ifa.done && done_at == 0) done_at = n;
      if (n == 2) begin
        check("b_sig", 32'(ifb.signature), 32'hEFDF);
        check("b_pass", 32'(ifb.pass), 32'h1);
      end
      cycle();
    end
    check("busy_len", 32'(busy_n), 32'd259);
    check("done_at", 32'(done_at), 32'd260);
    check("full_sig", 32'(ifa.signature), 32'(exp_full));
    check("c_pass", 32'(ifc.pass), 32'h1);

    // Abort in the 10th RUN cycle, then rerun; start while busy must be ignored
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int n = 2; n <= 14; n++) begin
      start = (n == 8);
      cycle();
    end
    start = 1'b0;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_busy", 32'(ifa.busy), 32'h0);
    check("abort_cut", 32'(ifa.cut_in), 32'h0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (262) cycle();
    check("rerun_sig", 32'(ifa.signature), 32'(exp_full));
    check("rerun_done", 32'(ifa.done), 32'h1);

    // Asynchronous reset mid-run
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (20) cycle();
    @(posedge CK);
    model_step();
    #2 RSTN = 1'b0;
    #1;
    check("arst_busy", 32'(ifa.busy), 32'h0);
    check("arst_cut", 32'(ifa.cut_in), 32'h0);
    check("arst_sig", 32'(ifa.signature), 32'hFFFF);
    model_reset();
    @(negedge CK);
    check_all();
    RSTN = 1'b1;

    // Random traffic
    for (int n = 0; n < 6000; n++) begin
      start   = ($urandom_range(0, 39) == 0);
      abort   = ($urandom_range(0, 299) == 0);
      cut_out = 1'($urandom_range(0, 1));
      cycle();
    end
    start = 1'b0;
    abort = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
